// File: rtl/onehot_grant_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : onehot_grant_encoder                                       |
// | Description : Registered request-vector serialiser. Accepts an N-bit     |
// |               request snapshot through a valid/ready handshake and       |
// |               emits the binary index of every set bit, one per output    |
// |               handshake, until the snapshot is drained.                  |
// |               Default order is lowest-index-first. Defining the macro    |
// |               ONEHOT_GRANT_RR_EN compiles in round-robin selection       |
// |               starting after the previous grant (last_grant register).   |
// | Ports       : clk, rst        - clock, synchronous active-high reset     |
// |               in_valid/in_ready/req - snapshot input handshake + vector  |
// |               out_valid/out_ready/out_idx/out_last - grant output        |
// |               zero_drop       - pulse when an all-zero snapshot is taken |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module onehot_grant_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_drop
);

    localparam logic [0:0]   c_ST_IDLE  = 1'b0;
    localparam logic [0:0]   c_ST_DRAIN = 1'b1;
    localparam logic [N-1:0] c_ONE      = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_zero_drop;
    logic [N-1:0]     r_pending;
`ifdef ONEHOT_GRANT_RR_EN
    logic [IDX_W-1:0] r_last_grant;
`endif

    logic [N-1:0]     w_pend_next;
    logic [N-1:0]     w_sel_src;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_pos;
    logic             w_sel_last;
    logic             w_out_hs;
    int               w_start;

    assign w_out_hs    = r_out_valid & out_ready;
    // Pending set as it will look once the currently presented index is taken.
    assign w_pend_next = r_pending & ~(c_ONE << r_out_idx);
    // In IDLE the selector looks at the incoming snapshot, in DRAIN at what
    // remains after the current handshake; only one is ever consumed.
    assign w_sel_src   = (r_state == c_ST_IDLE) ? req : w_pend_next;

`ifdef ONEHOT_GRANT_RR_EN
    // Search begins one past the most recent grant. In DRAIN the grant being
    // handshaken now becomes the most recent one, so use out_idx directly.
    always_comb begin
        w_start = 0;
        if (r_state == c_ST_IDLE) begin
            w_start = (int'(r_last_grant) + 1) % N;
        end else begin
            w_start = (int'(r_out_idx) + 1) % N;
        end
    end
`else
    assign w_start = 0;
`endif

    // Scan from the farthest position back toward the start so that the
    // closest set bit (in search order) is the one left standing.
    always_comb begin
        w_sel_idx = '0;
        w_pos     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IDX_W'((w_start + k) % N);
            if (w_sel_src[w_pos]) begin
                w_sel_idx = w_pos;
            end
        end
    end

    // Selected bit is the last one when nothing else remains in the source.
    assign w_sel_last = ((w_sel_src & ~(c_ONE << w_sel_idx)) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_zero_drop <= 1'b0;
            r_pending   <= '0;
`ifdef ONEHOT_GRANT_RR_EN
            r_last_grant <= IDX_W'(N - 1);
`endif
        end else begin
            r_zero_drop <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        if (req != '0) begin
                            r_pending   <= req;
                            r_state     <= c_ST_DRAIN;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_idx   <= w_sel_idx;
                            r_out_last  <= w_sel_last;
                        end else begin
                            r_zero_drop <= 1'b1;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_out_hs) begin
`ifdef ONEHOT_GRANT_RR_EN
                        r_last_grant <= r_out_idx;
`endif
                        r_pending <= w_pend_next;
                        if (w_pend_next != '0) begin
                            r_out_idx  <= w_sel_idx;
                            r_out_last <= w_sel_last;
                        end else begin
                            r_state     <= c_ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign zero_drop = r_zero_drop;

endmodule
`default_nettype wire
